// File: rtl/approx_part_sweep_ctrl.sv
// Exhaustive on-chip sweep of one approximated logic partition.
// Drives every input pattern and accumulates error metrics against the exact instance.
module approx_part_sweep_ctrl #(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 5,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   pi_drive,
    input  logic [N_OUT-1:0]  po_exact,
    input  logic [N_OUT-1:0]  po_approx,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     mismatch_cnt,
    output logic [N_IN+2:0]   ham_sum,
    output logic [N_OUT-1:0]  max_err,
    output logic [N_IN-1:0]   first_err_pat,
    output logic              first_err_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
    localparam logic [N_IN-1:0] PAT_LAST = '1;
    localparam logic [N_IN-1:0] PAT_ONE  = 1;
    localparam logic [N_IN:0]   MIS_ONE  = 1;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   pat_q, pat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN:0]     mis_q, mis_d;
    logic [N_IN+2:0]   ham_q, ham_d;
    logic [N_OUT-1:0]  max_q, max_d;
    logic [N_IN-1:0]   fpat_q, fpat_d;
    logic              fvld_q, fvld_d;

    logic [N_OUT-1:0]  diff_w;
    logic [N_OUT-1:0]  abs_w;
    logic [N_IN+2:0]   pop_w;

    function automatic logic [N_IN+2:0] popcnt(input logic [N_OUT-1:0] v);
        logic [N_IN+2:0] c;
        c = '0;
        for (int i = 0; i < N_OUT; i++) begin
            c = c + {{(N_IN+2){1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign diff_w = po_approx ^ po_exact;
    assign abs_w  = (po_approx >= po_exact) ? (po_approx - po_exact)
                                            : (po_exact - po_approx);
    assign pop_w  = popcnt(diff_w);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        ham_d   = ham_q;
        max_d   = max_q;
        fpat_d  = fpat_q;
        fvld_d  = fvld_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d = S_WAIT;
                    pat_d   = '0;
                    cnt_d   = SETTLE_L;
                    mis_d   = '0;
                    ham_d   = '0;
                    max_d   = '0;
                    fpat_d  = '0;
                    fvld_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (diff_w != '0) begin
                        mis_d = mis_q + MIS_ONE;
                        ham_d = ham_q + pop_w;
                        if (!fvld_q) begin
                            fpat_d = pat_q;
                            fvld_d = 1'b1;
                        end
                    end
                    if (abs_w > max_q) begin
                        max_d = abs_w;
                    end
                    // end of sweep detected before the counter could wrap
                    if (pat_q == PAT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        pat_d   = pat_q + PAT_ONE;
                        cnt_d   = SETTLE_L;
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            mis_q   <= '0;
            ham_q   <= '0;
            max_q   <= '0;
            fpat_q  <= '0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            ham_q   <= ham_d;
            max_q   <= max_d;
            fpat_q  <= fpat_d;
            fvld_q  <= fvld_d;
        end
    end

    assign pi_drive      = pat_q;
    assign busy          = (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done          = (state_q == S_DONE);
    assign mismatch_cnt  = mis_q;
    assign ham_sum       = ham_q;
    assign max_err       = max_q;
    assign first_err_pat = fpat_q;
    assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_approx_part_sweep_ctrl.sv
// Directed bench for approx_part_sweep_ctrl: default build plus a
// small N_IN=4/N_OUT=3/SETTLE=3 build.
module tb_approx_part_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  pi;
    logic [4:0]  ex;
    logic [4:0]  ap;
    logic        busy;
    logic        done;
    logic [8:0]  mis;
    logic [10:0] ham;
    logic [4:0]  mx;
    logic [7:0]  fpat;
    logic        fvld;

    logic        start2;
    logic        abort2;
    logic [3:0]  pi2;
    logic [2:0]  ex2;
    logic [2:0]  ap2;
    logic        busy2;
    logic        done2;
    logic [4:0]  mis2;
    logic [6:0]  ham2;
    logic [2:0]  mx2;
    logic [3:0]  fpat2;
    logic        fvld2;

    int mode;
    int pass_cnt;
    int fail_cnt;
    int total;
    int n;

    approx_part_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pi_drive(pi), .po_exact(ex), .po_approx(ap),
        .busy(busy), .done(done), .mismatch_cnt(mis), .ham_sum(ham),
        .max_err(mx), .first_err_pat(fpat), .first_err_vld(fvld)
    );

    approx_part_sweep_ctrl #(.N_IN(4), .N_OUT(3), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .pi_drive(pi2), .po_exact(ex2), .po_approx(ap2),
        .busy(busy2), .done(done2), .mismatch_cnt(mis2), .ham_sum(ham2),
        .max_err(mx2), .first_err_pat(fpat2), .first_err_vld(fvld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ex = pi[4:0];
        ap = pi[4:0];
        case (mode)
            1: ap = pi[4:0] ^ 5'b00001;
            2: begin
                ex = 5'b00000;
                ap = (pi == 8'hA5) ? 5'b10110 : 5'b00000;
            end
            default: ;
        endcase
    end

    assign ex2 = pi2[2:0];
    assign ap2 = ~pi2[2:0];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        fail_cnt = 0;
        total    = 0;
        mode     = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        start2   = 1'b0;
        abort2   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pi", 32'(pi), 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);
        chk("rst_ham", 32'(ham), 32'd0);
        chk("rst_max", 32'(mx), 32'd0);
        chk("rst_fvld", 32'(fvld), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // bit-exact approximation
        mode = 0;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        run_to_done(n);
        chk("t1_cycles", 32'(n), 32'd512);
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_mis", 32'(mis), 32'd0);
        chk("t1_ham", 32'(ham), 32'd0);
        chk("t1_max", 32'(mx), 32'd0);
        chk("t1_fvld", 32'(fvld), 32'd0);
        chk("t1_pi", 32'(pi), 32'hFF);

        // LSB flipped everywhere
        mode = 1;
        pulse_start();
        chk("t2_clr", 32'(mis), 32'd0);
        run_to_done(n);
        chk("t2_cycles", 32'(n), 32'd512);
        chk("t2_mis", 32'(mis), 32'd256);
        chk("t2_ham", 32'(ham), 32'd256);
        chk("t2_max", 32'(mx), 32'd1);
        chk("t2_fpat", 32'(fpat), 32'd0);
        chk("t2_fvld", 32'(fvld), 32'd1);

        // abort part-way, then restart
        pulse_start();
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_mis", 32'(mis), 32'd50);
        chk("ab_ham", 32'(ham), 32'd50);
        chk("ab_pi", 32'(pi), 32'd50);
        repeat (3) @(negedge clk);
        chk("ab_hold", 32'(mis), 32'd50);
        pulse_start();
        chk("ab_clr", 32'(mis), 32'd0);
        chk("ab_busy2", 32'(busy), 32'd1);
        run_to_done(n);
        chk("ab_cycles", 32'(n), 32'd512);
        chk("ab_mis_fin", 32'(mis), 32'd256);
        chk("ab_ham_fin", 32'(ham), 32'd256);

        // asynchronous reset mid-sweep
        pulse_start();
        repeat (299) @(negedge clk);
        chk("rs_pre_mis", 32'(mis), 32'd149);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_pi", 32'(pi), 32'd0);
        chk("rs_mis", 32'(mis), 32'd0);
        chk("rs_ham", 32'(ham), 32'd0);
        chk("rs_max", 32'(mx), 32'd0);
        chk("rs_fvld", 32'(fvld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rs_noresume", 32'(busy), 32'd0);

        // start+abort together from IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("sa_idle_busy", 32'(busy), 32'd0);

        // single fault; extra start while busy is ignored
        mode = 2;
        pulse_start();
        repeat (50) @(negedge clk);
        pulse_start();
        run_to_done(n);
        chk("sf_cycles", 32'(n), 32'd461);
        chk("sf_mis", 32'(mis), 32'd1);
        chk("sf_ham", 32'(ham), 32'd3);
        chk("sf_max", 32'(mx), 32'd22);
        chk("sf_fpat", 32'(fpat), 32'hA5);
        chk("sf_fvld", 32'(fvld), 32'd1);

        // start+abort together from DONE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_done_done", 32'(done), 32'd1);
        chk("sa_done_busy", 32'(busy), 32'd0);
        chk("sa_done_mis", 32'(mis), 32'd1);

        // small build, all outputs inverted
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("s2_cycles", 32'(n), 32'd64);
        chk("s2_mis", 32'(mis2), 32'd16);
        chk("s2_ham", 32'(ham2), 32'd48);
        chk("s2_max", 32'(mx2), 32'd7);
        chk("s2_fpat", 32'(fpat2), 32'd0);
        chk("s2_fvld", 32'(fvld2), 32'd1);
        chk("s2_pi", 32'(pi2), 32'hF);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
